// File: rtl/smm_job_scheduler.sv
// smm_job_scheduler: round-robin scheduler that time-shares a single 4x4
// Strassen block-multiply engine among NREQ requesters. One job is in flight
// at a time. A job is latched at grant, issued to the engine, and then waited
// out for a fixed engine latency. The result is returned over a valid/ready
// response channel.
module smm_job_scheduler #(
  parameter int NREQ      = 4,
  parameter int DATAWIDTH = 32,
  parameter int BUSWIDTH  = DATAWIDTH * 16,
  parameter int LATENCY   = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0]          req_sel,
  input  logic [NREQ*BUSWIDTH-1:0] req_a,
  input  logic [NREQ*BUSWIDTH-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [BUSWIDTH-1:0]      rsp_c,
  output logic                     eng_load,
  output logic                     eng_sel,
  output logic [BUSWIDTH-1:0]      eng_a,
  output logic [BUSWIDTH-1:0]      eng_b,
  input  logic [BUSWIDTH-1:0]      eng_c,
  output logic                     busy,
  output logic [15:0]              jobs_done
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [IDW-1:0]      rr_ptr_q, id_q, grant_idx, cand;
  logic                grant_any, accept, rsp_fire;
  logic [BUSWIDTH-1:0] a_q, b_q, rsp_c_q;
  logic                sel_q;
  logic [CW-1:0]       cnt_q;
  logic [15:0]         jobs_done_q;

  // Round-robin pick: offsets are walked from high to low, so the lowest
  // offset from rr_ptr that holds a valid request wins.
  // NOTE: every always_comb output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = IDW'((int'(rr_ptr_q) + i) % NREQ);
      if (req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign accept   = (state_q == S_IDLE) && grant_any;
  assign rsp_fire = (state_q == S_RESP) && rsp_ready;

  // Next-state logic and the one-hot accept pulse, which exists only in IDLE.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          req_ready[grant_idx] = 1'b1;
          state_d              = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (cnt_q == '0) state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register. A reset in any state drops the job in flight.
  // NOTE: sequential state uses non-blocking <= so every register samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Job datapath: operand latch, latency counter, result capture, fairness pointer and job counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= 1'b0;
      id_q        <= '0;
      cnt_q       <= '0;
      rsp_c_q     <= '0;
      rr_ptr_q    <= '0;
      jobs_done_q <= '0;
    end else begin
      if (accept) begin
        a_q   <= req_a[int'(grant_idx) * BUSWIDTH +: BUSWIDTH];
        b_q   <= req_b[int'(grant_idx) * BUSWIDTH +: BUSWIDTH];
        sel_q <= req_sel[grant_idx];
        id_q  <= grant_idx;
      end
      if (state_q == S_ISSUE) cnt_q <= CW'(LATENCY - 1);
      else if (state_q == S_WAIT && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      // The engine result is valid only in the final WAIT cycle, so it is captured there.
      if (state_q == S_WAIT && cnt_q == '0) rsp_c_q <= eng_c;
      if (rsp_fire) begin
        jobs_done_q <= jobs_done_q + 16'd1;
        rr_ptr_q    <= IDW'((int'(id_q) + 1) % NREQ);
      end
    end
  end

  assign eng_load  = (state_q == S_ISSUE);
  assign eng_sel   = sel_q;
  assign eng_a     = a_q;
  assign eng_b     = b_q;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_id    = id_q;
  assign rsp_c     = rsp_c_q;
  assign busy      = (state_q != S_IDLE);
  assign jobs_done = jobs_done_q;

endmodule

// File: tb/tb_smm_job_scheduler.sv
// Testbench for smm_job_scheduler. The bench plays the role of the engine
// (a 4x4 multiply whose result is visible only in cycle load+LATENCY). It also
// keeps a job-age model of the scheduler that is compared every cycle, and it
// runs directed scenarios that carry literal expectations.
module tb_smm_job_scheduler;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int BW = DW * 16;
  localparam int L  = 12;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, req_sel;
  logic [N*BW-1:0] req_a, req_b;
  logic            rsp_valid, rsp_ready;
  logic [1:0]      rsp_id;
  logic [BW-1:0]   rsp_c, eng_a, eng_b, eng_c;
  logic            eng_load, eng_sel, busy;
  logic [15:0]     jobs_done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // engine model state
  int            eng_t = -1;
  logic [BW-1:0] eng_res;

  // scheduler model state (valid for the cycle currently being sampled)
  bit            m_known = 0;
  bit            m_active;
  int            m_age, m_id, m_rr;
  logic [BW-1:0] m_a, m_b, m_c;
  logic          m_sel;
  logic [15:0]   m_done;

  // grant log
  int g_cyc[$];
  int g_idx[$];

  smm_job_scheduler #(.NREQ(N), .DATAWIDTH(DW), .BUSWIDTH(BW), .LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_c(rsp_c),
    .eng_load(eng_load), .eng_sel(eng_sel), .eng_a(eng_a), .eng_b(eng_b), .eng_c(eng_c),
    .busy(busy), .jobs_done(jobs_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // 4x4 engine: sel=0 matrix product, sel=1 element-wise (reduced) product, wrapping arithmetic.
  function automatic logic [BW-1:0] eng_model(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic sel);
    logic [BW-1:0] c;
    logic [DW-1:0] acc;
    c = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        if (sel) acc = a[(i*4+j)*DW +: DW] * b[(i*4+j)*DW +: DW];
        else begin
          acc = '0;
          for (int k = 0; k < 4; k++) acc += a[(i*4+k)*DW +: DW] * b[(k*4+j)*DW +: DW];
        end
        c[(i*4+j)*DW +: DW] = acc;
      end
    return c;
  endfunction

  function automatic logic [BW-1:0] rand_bus();
    logic [BW-1:0] v;
    for (int i = 0; i < 16; i++) v[i*DW +: DW] = $urandom_range(0, 1000) - 500;
    return v;
  endfunction

  // cycle counter and engine output: the product shows only in cycle load+L, otherwise junk
  always @(posedge clk) begin
    cyc++;
    #1;
    if (eng_t >= 0 && cyc == eng_t + L) eng_c = eng_res;
    else                                eng_c = {16{cyc ^ 32'hA5A5_0000}};
  end

  always @(negedge clk) begin
    if (eng_load === 1'b1) begin
      eng_t   = cyc;
      eng_res = eng_model(eng_a, eng_b, eng_sel);
    end
  end

  // model compare and model advance, once per cycle
  always @(negedge clk) begin
    logic [N-1:0] exp_ready;
    int           exp_g;
    bit           exp_rv;
    exp_ready = '0;
    exp_g     = -1;
    if (m_known && !m_active)
      for (int i = N - 1; i >= 0; i--) if (req_valid[(m_rr + i) % N]) exp_g = (m_rr + i) % N;
    if (exp_g >= 0) exp_ready[exp_g] = 1'b1;
    exp_rv = m_active && (m_age >= L + 2);
    if (m_known) begin
      check("m_req_ready", req_ready, exp_ready);
      check("m_busy", busy, m_active);
      check("m_eng_load", eng_load, m_active && m_age == 1);
      check("m_rsp_valid", rsp_valid, exp_rv);
      check("m_jobs_done", jobs_done, m_done);
      if (exp_rv) begin
        check("m_rsp_id", rsp_id, m_id);
        check("m_rsp_c", rsp_c, m_c);
      end
      if (m_active) begin
        check("m_eng_a", eng_a, m_a);
        check("m_eng_b", eng_b, m_b);
        check("m_eng_sel", eng_sel, m_sel);
      end
    end
    for (int i = 0; i < N; i++)
      if (req_ready[i] === 1'b1) begin
        g_cyc.push_back(cyc);
        g_idx.push_back(i);
      end
    if (rst === 1'b1) begin
      m_known  = 1;
      m_active = 0;
      m_age    = 0;
      m_rr     = 0;
      m_done   = '0;
    end else if (m_known) begin
      if (!m_active) begin
        if (exp_g >= 0) begin
          m_active = 1;
          m_age    = 1;
          m_id     = exp_g;
          m_a      = req_a[exp_g*BW +: BW];
          m_b      = req_b[exp_g*BW +: BW];
          m_sel    = req_sel[exp_g];
          m_c      = eng_model(m_a, m_b, m_sel);
        end
      end else if (m_age >= L + 2) begin
        if (rsp_ready) begin
          m_done   = m_done + 16'd1;
          m_rr     = (m_id + 1) % N;
          m_active = 0;
        end
      end else m_age++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output int t, output int idx);
    t   = -1;
    idx = -1;
    for (int n = 0; n < 200 && t < 0; n++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (req_ready[i] === 1'b1) begin t = cyc; idx = i; end
    end
    if (t < 0) fail_now("grant_wait");
  endtask

  task automatic wait_rsp(output int t);
    t = -1;
    for (int n = 0; n < 200 && t < 0; n++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) t = cyc;
    end
    if (t < 0) fail_now("rsp_wait");
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (busy === 1'b0) done = 1;
    end
    if (!done) fail_now("idle_wait");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BW-1:0] ident, a1, b1;
    int t_a, t_r, t_g, t_l, t_rel, g, n;
    int exp_seq[5];
    bit hit;
    exp_seq = '{0, 1, 2, 3, 0};
    ident = '0;
    for (int i = 0; i < 4; i++) ident[(i*4+i)*DW +: DW] = 32'd1;

    rst = 1'b1; req_valid = '0; req_sel = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    eng_c = '0;
    step(); step();
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_eng_load", eng_load, 0);
    check("rst_jobs_done", jobs_done, 0);
    check("rst_eng_a", eng_a, 0);
    step(); rst = 1'b0;

    // 1: single job from requester 2, identity x identity
    req_a[2*BW +: BW] = ident; req_b[2*BW +: BW] = ident; req_valid = 4'b0100;
    wait_grant(t_a, g);
    check("t1_ready", req_ready, 4'b0100);
    check("t1_gidx", g, 2);
    step(); req_valid = '0;
    wait_rsp(t_r);
    check("t1_load_cycle", eng_t, t_a + 1);
    check("t1_latency", t_r - t_a, 14);
    check("t1_rsp_id", rsp_id, 2);
    check("t1_rsp_c", rsp_c, ident);
    step();
    @(negedge clk);
    check("t1_jobs_done", jobs_done, 1);

    // 2: all requesters continuously valid after a fresh reset
    step(); rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_a[i*BW +: BW] = rand_bus();
      req_b[i*BW +: BW] = rand_bus();
    end
    req_sel = 4'b0101;
    g_cyc.delete(); g_idx.delete();
    req_valid = 4'b1111;
    for (n = 0; n < 120 && g_idx.size() < 5; n++) begin @(negedge clk); #1; end
    step(); req_valid = '0;
    if (g_idx.size() < 5) fail_now("t2_grants");
    else
      for (int k = 0; k < 5; k++) begin
        check("t2_grant_order", g_idx[k], exp_seq[k]);
        if (k > 0) check("t2_grant_spacing", g_cyc[k] - g_cyc[k-1], 15);
      end
    wait_idle();
    req_sel = '0;

    // 3: backpressure hold for 20 cycles with requester 0 waiting
    step(); rsp_ready = 1'b0; req_valid = 4'b0011;
    wait_grant(t_a, g);
    check("t3_gidx", g, 1);
    step(); req_valid = 4'b0001;
    wait_rsp(t_r);
    g_idx.delete(); g_cyc.delete();
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      check("t3_hold_valid", rsp_valid, 1);
      check("t3_hold_id", rsp_id, 1);
    end
    check("t3_no_grant", g_idx.size(), 0);
    step(); rsp_ready = 1'b1; t_rel = cyc;
    wait_grant(t_g, g);
    check("t3_next_grant_cycle", t_g - t_rel, 1);
    check("t3_next_gidx", g, 0);
    step(); req_valid = '0;
    wait_idle();

    // 4: sel passthrough and operand stability for requester 1
    a1 = rand_bus(); b1 = rand_bus();
    step(); req_a[BW +: BW] = a1; req_b[BW +: BW] = b1; req_sel = 4'b0010; req_valid = 4'b0010;
    wait_grant(t_a, g);
    check("t4_gidx", g, 1);
    hit = 0;
    for (n = 0; n < 40 && !hit; n++) begin
      step(); req_valid = '0;
      req_a[BW +: BW] = ~req_a[BW +: BW];
      req_b[BW +: BW] = req_b[BW +: BW] ^ {16{32'h0000_FFFF}};
      @(negedge clk);
      if (busy === 1'b0) hit = 1;
      else begin
        check("t4_eng_sel", eng_sel, 1);
        check("t4_eng_a", eng_a, a1);
        check("t4_eng_b", eng_b, b1);
      end
    end
    if (!hit) fail_now("t4_job_end");
    req_sel = '0;

    // 5: reset five cycles after eng_load, then a request from requester 3
    step(); req_a[2*BW +: BW] = rand_bus(); req_valid = 4'b0100;
    wait_grant(t_a, g);
    check("t5_gidx", g, 2);
    step(); req_valid = '0;
    t_l = -1;
    for (n = 0; n < 20 && t_l < 0; n++) begin
      @(negedge clk);
      if (eng_load === 1'b1) t_l = cyc;
    end
    if (t_l < 0) fail_now("t5_load_wait");
    repeat (5) step();
    rst = 1'b1;
    step(); rst = 1'b0;
    @(negedge clk);
    check("t5_busy", busy, 0);
    check("t5_rsp_valid", rsp_valid, 0);
    check("t5_eng_load", eng_load, 0);
    check("t5_jobs_done", jobs_done, 0);
    step(); req_valid = 4'b1000;
    wait_grant(t_a, g);
    check("t5_gidx_after_rst", g, 3);
    step(); req_valid = '0;
    wait_idle();

    // 6: jobs_done wraps from 0xFFFF to 0
    step();
    force dut.jobs_done_q = 16'hFFFF;
    m_done = 16'hFFFF;
    step();
    release dut.jobs_done_q;
    req_valid = 4'b0001;
    wait_grant(t_a, g);
    step(); req_valid = '0;
    wait_idle();
    check("t6_wrap", jobs_done, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
